core_run_controller: RTL and testbench

- Run/step/breakpoint controller for the single-cycle RISC-V DataPath on the FPGA board.
- Drives the DataPath clock-enable from a board switch and pushbutton so the core can free-run, single-step one instruction, or stop at a PC breakpoint or an EBREAK.
- Counts enabled cycles so the LED/SSD debug selectors can display them.
- Sits between the board I/O and the DataPath and shares its clk and reset.

---
 rtl/core_run_controller_if.sv | 28 ++
 rtl/core_run_controller.sv | 115 +++++++++++
 tb/tb_core_run_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_controller_if.sv
// Board-side and DataPath-side signals of the run/step/breakpoint controller.
// The controller takes the slave modport; the board/DataPath glue takes master.
interface core_run_controller_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             run_sw;
  logic             step_btn;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             halt_req;
  logic             cnt_clr;
  logic             cpu_en;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run_sw, step_btn, bp_en, bp_addr, pc, halt_req, cnt_clr,
    input  cpu_en, state, halted, cycle_count
  );

  modport slave (
    input  run_sw, step_btn, bp_en, bp_addr, pc, halt_req, cnt_clr,
    output cpu_en, state, halted, cycle_count
  );
endinterface

// File: rtl/core_run_controller.sv
// Run/step/breakpoint controller for the single-cycle RISC-V DataPath: gates the
// core clock-enable from a switch, a step button, a PC breakpoint and EBREAK/ECALL.
module core_run_controller #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  core_run_controller_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] BREAK = 2'd3;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             run_s1, run_s2;
  logic             step_s1, step_s2, step_s3;
  logic             run_s;
  logic             step_pulse;
  logic             bp_armed;
  logic             bp_hit;
  logic [PC_W-1:0]  pc_diff;
  logic             cpu_en;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: state is assigned with <= so every flop samples pre-edge values;
  // async reset sits in the sensitivity list so outputs clear without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_s1  <= 1'b0;
      run_s2  <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      run_s1  <= bus.run_sw;
      run_s2  <= run_s1;
      step_s1 <= bus.step_btn;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  assign run_s      = run_s2;
  assign step_pulse = step_s2 & ~step_s3;

  assign pc_diff = bus.pc ^ bus.bp_addr;
  assign bp_hit  = bus.bp_en & bp_armed & ~|pc_diff;

  // The breakpoint instruction itself is held off; EBREAK in RUN still retires.
  assign cpu_en = ((state_q == RUN) & ~bp_hit) | (state_q == STEP);

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_s)           state_d = RUN;
        else if (step_pulse) state_d = STEP;
      end
      RUN: begin
        if (!run_s)            state_d = IDLE;
        else if (bus.halt_req) state_d = BREAK;
        else if (bp_hit)       state_d = BREAK;
      end
      STEP: begin
        state_d = bus.halt_req ? BREAK : IDLE;
      end
      BREAK: begin
        if (!run_s)          state_d = IDLE;
        else if (step_pulse) state_d = STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disarm on entry to RUN so a resume executes the instruction at bp_addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_armed <= 1'b0;
    end else if ((state_d == RUN) && (state_q != RUN)) begin
      bp_armed <= 1'b0;
    end else if (state_q == RUN) begin
      bp_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (cpu_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.cpu_en      = cpu_en;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == IDLE) | (state_q == BREAK);
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: cycle table for breakpoint/EBREAK/step, directed
// corner sequences, then random stimulus against a behavioural model.
module tb_core_run_controller;

  localparam int              PC_W    = 32;
  localparam int              CNT_W   = 4;
  localparam int              CNT_MAX = 15;
  localparam logic [PC_W-1:0] BP      = 32'h10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  core_run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  core_run_controller #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3} mode_e;
  mode_e m_mode;
  int    m_run_age;
  int    m_count;
  bit    run_h [3];
  bit    step_h[3];

  function automatic bit model_en();
    bit hit;
    hit = bus.bp_en && (m_run_age > 0) && (bus.pc == bus.bp_addr);
    return (m_mode == M_RUN && !hit) || (m_mode == M_STEP);
  endfunction

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_run_age = 0;
    m_count   = 0;
    for (int i = 0; i < 3; i++) begin
      run_h[i]  = 1'b0;
      step_h[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit    run_seen, press, en, hit;
    mode_e nxt;
    run_seen = run_h[1];
    press    = step_h[1] && !step_h[2];
    en       = model_en();
    hit      = bus.bp_en && (m_run_age > 0) && (bus.pc == bus.bp_addr);
    if (bus.cnt_clr)  m_count = 0;
    else if (en)      m_count = (m_count >= CNT_MAX) ? CNT_MAX : m_count + 1;
    nxt = m_mode;
    case (m_mode)
      M_IDLE:  nxt = run_seen ? M_RUN : (press ? M_STEP : M_IDLE);
      M_RUN:   nxt = !run_seen ? M_IDLE : ((bus.halt_req || hit) ? M_BREAK : M_RUN);
      M_STEP:  nxt = bus.halt_req ? M_BREAK : M_IDLE;
      default: nxt = !run_seen ? M_IDLE : (press ? M_STEP : M_BREAK);
    endcase
    if (nxt == M_RUN && m_mode != M_RUN) m_run_age = 0;
    else if (m_mode == M_RUN && m_run_age < 2) m_run_age++;
    m_mode    = nxt;
    run_h[2]  = run_h[1];
    run_h[1]  = run_h[0];
    run_h[0]  = bus.run_sw;
    step_h[2] = step_h[1];
    step_h[1] = step_h[0];
    step_h[0] = bus.step_btn;
  endtask

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset        = 1'b1;
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.cnt_clr  = 1'b0;
    bus.pc       = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic             run_sw;
    logic             step_btn;
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic [1:0]       st;
    logic             en;
    logic             hl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int steps;
    int seen;

    // Row i: inputs driven for cycle i, outputs expected during that cycle.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 1'b1, 4'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h00, 2'd1, 1'b1, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h04, 2'd1, 1'b1, 1'b0, 4'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h08, 2'd1, 1'b1, 1'b0, 4'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 2'd1, 1'b1, 1'b0, 4'd3};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd1, 1'b0, 1'b0, 4'd4};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h10, 2'd3, 1'b0, 1'b1, 4'd4};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h10, 2'd3, 1'b0, 1'b1, 4'd4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h10, 2'd3, 1'b0, 1'b1, 4'd4};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd0, 1'b0, 1'b1, 4'd4};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd0, 1'b0, 1'b1, 4'd4};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd0, 1'b0, 1'b1, 4'd4};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h10, 2'd1, 1'b1, 1'b0, 4'd4};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h14, 2'd1, 1'b1, 1'b0, 4'd5};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h18, 2'd1, 1'b1, 1'b0, 4'd6};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h1C, 2'd1, 1'b1, 1'b0, 4'd7};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h20, 2'd1, 1'b1, 1'b0, 4'd8};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 32'h24, 2'd1, 1'b1, 1'b0, 4'd9};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 32'h28, 2'd3, 1'b0, 1'b1, 4'd10};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 32'h28, 2'd3, 1'b0, 1'b1, 4'd10};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 32'h28, 2'd3, 1'b0, 1'b1, 4'd10};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 32'h28, 2'd2, 1'b1, 1'b0, 4'd10};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 32'h2C, 2'd0, 1'b0, 1'b1, 4'd11};
    tbl[25] = '{1'b1, 1'b1, 1'b0, 32'h2C, 2'd1, 1'b1, 1'b0, 4'd11};

    bus.bp_en   = 1'b1;
    bus.bp_addr = BP;
    do_reset();

    // ---- breakpoint / resume / EBREAK / step-from-BREAK table ----
    for (int i = 0; i < 26; i++) begin
      bus.run_sw   = tbl[i].run_sw;
      bus.step_btn = tbl[i].step_btn;
      bus.halt_req = tbl[i].halt_req;
      bus.pc       = tbl[i].pc;
      #1;
      check($sformatf("vec%0d_state", i), 64'(bus.state), 64'(tbl[i].st));
      check($sformatf("vec%0d_cpu_en", i), 64'(bus.cpu_en), 64'(tbl[i].en));
      check($sformatf("vec%0d_halted", i), 64'(bus.halted), 64'(tbl[i].hl));
      check($sformatf("vec%0d_count", i), 64'(bus.cycle_count), 64'(tbl[i].cnt));
      @(negedge clk);
    end

    // ---- asynchronous reset mid-RUN, held 3 cycles with run_sw=1 ----
    #1;
    check("pre_reset_run", 64'(bus.cpu_en), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_state", 64'(bus.state), 64'(0));
    check("rst_async_cpu_en", 64'(bus.cpu_en), 64'(0));
    check("rst_async_halted", 64'(bus.halted), 64'(1));
    check("rst_async_count", 64'(bus.cycle_count), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_hold_state", 64'(bus.state), 64'(0));
      check("rst_hold_cpu_en", 64'(bus.cpu_en), 64'(0));
    end
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 6 && seen == 0; i++) begin
      @(negedge clk);
      #1;
      if (bus.state == 2'd1) seen = 1;
    end
    check("rst_release_run", 64'(seen), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_run_cpu_en", 64'(bus.cpu_en), 64'(1));
    end

    // ---- held step button gives exactly one STEP per press ----
    do_reset();
    for (int press = 1; press <= 2; press++) begin
      steps        = 0;
      bus.step_btn = 1'b1;
      for (int i = 0; i < 25; i++) begin
        if (i == 20) bus.step_btn = 1'b0;
        @(negedge clk);
        #1;
        if (bus.state == 2'd2 && bus.cpu_en) steps++;
      end
      check("step_once", 64'(steps), 64'(1));
      check("step_back_idle", 64'(bus.state), 64'(0));
      check("step_count", 64'(bus.cycle_count), 64'(press));
    end

    // ---- run_sw and step_btn rise together in IDLE: RUN wins ----
    do_reset();
    repeat (3) @(negedge clk);
    bus.run_sw   = 1'b1;
    bus.step_btn = 1'b1;
    @(negedge clk); #1;
    check("prio_edge_k", 64'(bus.state), 64'(0));
    @(negedge clk); #1;
    check("prio_edge_k1", 64'(bus.state), 64'(0));
    @(negedge clk); #1;
    check("prio_edge_k2_run", 64'(bus.state), 64'(1));
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.state == 2'd2) steps++;
    end
    check("prio_no_step", 64'(steps), 64'(0));

    // ---- saturation then synchronous clear ----
    repeat (20) @(negedge clk);
    #1;
    check("sat_count", 64'(bus.cycle_count), 64'(CNT_MAX));
    check("sat_cpu_en", 64'(bus.cpu_en), 64'(1));
    bus.cnt_clr = 1'b1;
    @(negedge clk); #1;
    check("clr_zero", 64'(bus.cycle_count), 64'(0));
    bus.cnt_clr = 1'b0;
    @(negedge clk); #1;
    check("clr_then_one", 64'(bus.cycle_count), 64'(1));

    // ---- random stimulus against the model ----
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 11) == 0) bus.run_sw   = ~bus.run_sw;
      if ($urandom_range(0, 3) == 0)  bus.step_btn = ~bus.step_btn;
      if ($urandom_range(0, 29) == 0) bus.bp_en    = ~bus.bp_en;
      bus.halt_req = ($urandom_range(0, 9) == 0);
      bus.cnt_clr  = ($urandom_range(0, 39) == 0);
      bus.pc       = PC_W'($urandom_range(0, 7) * 4);
      #1;
      check("rnd_state", 64'(bus.state), 64'(int'(m_mode)));
      check("rnd_cpu_en", 64'(bus.cpu_en), 64'(model_en()));
      check("rnd_halted", 64'(bus.halted), 64'(m_mode == M_IDLE || m_mode == M_BREAK));
      check("rnd_count", 64'(bus.cycle_count), 64'(m_count));
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
